// File: rtl/z_result_unit.sv
// Result capture stage behind the ALU: waits out multi-cycle op latency, latches the Z pair and HI/LO.
// Optional ZSTATUS_EN adds registered z_zero/z_neg flags taken from the captured low word.
module z_result_unit #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        zhi_out,
    input  logic        zlo_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] bus_out
`ifdef ZSTATUS_EN
    ,
    output logic        z_zero,
    output logic        z_neg
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [4:0]  r_op_q;
    logic [31:0] r_z_hi;
    logic [31:0] r_z_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [1:0]  w_state_next;
    logic [3:0]  w_cnt_next;
    logic [4:0]  w_op_next;
    logic [3:0]  w_load_cnt;
    logic        w_capture;
    logic        w_hilo_wr;

    // Wait count chosen from the incoming op at the moment start is accepted
    always_comb begin
        w_load_cnt = 4'd0;
        if (op == OP_MUL) begin
            w_load_cnt = MUL_CNT;
        end else if (op == OP_DIV) begin
            w_load_cnt = DIV_CNT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op_q;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_next  = op;
                    w_cnt_next = w_load_cnt;
                    if (w_load_cnt == 4'd0) begin
                        w_state_next = ST_CAPT;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                // The <= guards a zero count ever reaching WAIT, so it can never wrap
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_CAPT;
                end
            end
            ST_CAPT: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_capture = (r_state == ST_CAPT);
    assign w_hilo_wr = w_capture && ((r_op_q == OP_MUL) || (r_op_q == OP_DIV));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op_q  <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op_q  <= w_op_next;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_z_hi <= 32'd0;
            r_z_lo <= 32'd0;
        end else if (w_capture) begin
            r_z_hi <= alu_hi;
            r_z_lo <= alu_lo;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_hilo_wr) begin
            r_hi <= alu_hi;
            r_lo <= alu_lo;
        end
    end

`ifdef ZSTATUS_EN
    logic r_z_zero;
    logic r_z_neg;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_z_zero <= 1'b0;
            r_z_neg  <= 1'b0;
        end else if (w_capture) begin
            r_z_zero <= (alu_lo == 32'd0);
            r_z_neg  <= alu_lo[31];
        end
    end

    assign z_zero = r_z_zero;
    assign z_neg  = r_z_neg;
`endif

    assign busy = (r_state == ST_WAIT) || (r_state == ST_CAPT);
    assign done = (r_state == ST_DONE);
    assign z_hi = r_z_hi;
    assign z_lo = r_z_lo;
    assign hi_q = r_hi;
    assign lo_q = r_lo;

    // Low half wins when both bus enables are raised
    always_comb begin
        bus_out = 32'd0;
        if (zlo_out) begin
            bus_out = r_z_lo;
        end else if (zhi_out) begin
            bus_out = r_z_hi;
        end
    end

endmodule

// File: tb/tb_z_result_unit.sv
// Directed-vector bench for z_result_unit: latency, HI/LO update rules, start handling, clear abort, bus mux.
module tb_z_result_unit;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b01111;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  op;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        zhi_out;
    logic        zlo_out;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] bus_out;
`ifdef ZSTATUS_EN
    logic        z_zero;
    logic        z_neg;
`endif

    int checks = 0;
    int errors = 0;

    z_result_unit #(
        .MUL_LAT(2),
        .DIV_LAT(1)
    ) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .alu_hi (alu_hi),
        .alu_lo (alu_lo),
        .zhi_out(zhi_out),
        .zlo_out(zlo_out),
        .busy   (busy),
        .done   (done),
        .z_hi   (z_hi),
        .z_lo   (z_lo),
        .hi_q   (hi_q),
        .lo_q   (lo_q),
        .bus_out(bus_out)
`ifdef ZSTATUS_EN
        ,
        .z_zero (z_zero),
        .z_neg  (z_neg)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op with start sampled at edge 0 and check the busy/done timeline and the Z pair
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] hi,
                          input logic [31:0] lo, input int lat);
        op     = o;
        alu_hi = hi;
        alu_lo = lo;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            check_val($sformatf("%s busy c%0d", name, c), {31'd0, busy}, 32'd1);
            check_val($sformatf("%s done c%0d", name, c), {31'd0, done}, 32'd0);
            step();
        end
        check_val($sformatf("%s done c%0d", name, lat + 2), {31'd0, done}, 32'd1);
        check_val($sformatf("%s busy c%0d", name, lat + 2), {31'd0, busy}, 32'd0);
        check_val({name, " z_hi"}, z_hi, hi);
        check_val({name, " z_lo"}, z_lo, lo);
        step();
        check_val({name, " done drop"}, {31'd0, done}, 32'd0);
        $display("op %s: op=%b hi=%h lo=%h -> z_hi=%h z_lo=%h hi_q=%h lo_q=%h",
                 name, o, hi, lo, z_hi, z_lo, hi_q, lo_q);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        clear   = 1'b1;
        start   = 1'b0;
        op      = 5'd0;
        alu_hi  = 32'd0;
        alu_lo  = 32'd0;
        zhi_out = 1'b0;
        zlo_out = 1'b0;
        step();
        step();
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done", {31'd0, done}, 32'd0);
        check_val("rst z_hi", z_hi, 32'd0);
        check_val("rst z_lo", z_lo, 32'd0);
        check_val("rst hi_q", hi_q, 32'd0);
        check_val("rst lo_q", lo_q, 32'd0);
        check_val("rst bus", bus_out, 32'd0);
        clear = 1'b0;
        step();
        $display("reset released");

        // Single-cycle op leaves HI/LO at their reset value
        run_op("add1", OP_ADD, 32'd0, 32'h5, 0);
        check_val("add1 hi_q", hi_q, 32'd0);
        check_val("add1 lo_q", lo_q, 32'd0);

        run_op("mul", OP_MUL, 32'h1, 32'hFFFF0000, 2);
        check_val("mul hi_q", hi_q, 32'h1);
        check_val("mul lo_q", lo_q, 32'hFFFF0000);

        run_op("add2", OP_ADD, 32'h12345678, 32'h9, 0);
        check_val("add2 hi_q hold", hi_q, 32'h1);
        check_val("add2 lo_q hold", lo_q, 32'hFFFF0000);

        // start held across 8 edges with DIV: accepts at edges 0 and 4 only
        op     = OP_DIV;
        alu_hi = 32'h7;
        alu_lo = 32'h3;
        start  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) start = 1'b0;
            check_val($sformatf("divhold done c%0d", c), {31'd0, done},
                      ((c == 3) || (c == 7)) ? 32'd1 : 32'd0);
        end
        check_val("divhold hi_q", hi_q, 32'h7);
        check_val("divhold lo_q", lo_q, 32'h3);
        step();
        check_val("divhold idle busy", {31'd0, busy}, 32'd0);
        check_val("divhold idle done", {31'd0, done}, 32'd0);
        $display("divhold: hi_q=%h lo_q=%h", hi_q, lo_q);

        // clear in the second WAIT cycle of a MUL aborts without capture
        op     = OP_MUL;
        alu_hi = 32'h55;
        alu_lo = 32'h66;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        check_val("abort busy before", {31'd0, busy}, 32'd1);
        #2 clear = 1'b1;
        #1;
        check_val("abort busy", {31'd0, busy}, 32'd0);
        check_val("abort done", {31'd0, done}, 32'd0);
        check_val("abort z_hi", z_hi, 32'd0);
        check_val("abort z_lo", z_lo, 32'd0);
        check_val("abort hi_q", hi_q, 32'd0);
        check_val("abort lo_q", lo_q, 32'd0);
        #1 clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_val($sformatf("abort quiet done %0d", c), {31'd0, done}, 32'd0);
            check_val($sformatf("abort quiet busy %0d", c), {31'd0, busy}, 32'd0);
        end
        check_val("abort no capture", z_lo, 32'd0);
        check_val("abort hi_q stays", hi_q, 32'd0);
        $display("abort: outputs cleared, no done");
        run_op("add3", OP_ADD, 32'd0, 32'h5, 0);
        check_val("add3 hi_q", hi_q, 32'd0);

        // Bus mux
        run_op("busld", OP_ADD, 32'hAAAA0000, 32'h0000BBBB, 0);
        zhi_out = 1'b1;
        zlo_out = 1'b0;
        #1 check_val("bus zhi", bus_out, 32'hAAAA0000);
        zlo_out = 1'b1;
        #1 check_val("bus both", bus_out, 32'h0000BBBB);
        zhi_out = 1'b0;
        #1 check_val("bus zlo", bus_out, 32'h0000BBBB);
        zlo_out = 1'b0;
        #1 check_val("bus none", bus_out, 32'd0);
        $display("bus: mux selections done");

`ifdef ZSTATUS_EN
        run_op("zst0", OP_ADD, 32'd0, 32'd0, 0);
        check_val("zst0 z_zero", {31'd0, z_zero}, 32'd1);
        check_val("zst0 z_neg", {31'd0, z_neg}, 32'd0);
        run_op("zstn", OP_ADD, 32'd0, 32'h80000000, 0);
        check_val("zstn z_zero", {31'd0, z_zero}, 32'd0);
        check_val("zstn z_neg", {31'd0, z_neg}, 32'd1);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
